// File: rtl/paralelo_serial_pkg.sv
// Shared constants and state encoding for the paralelo/serial line stages.
// Reused by the matching serial-to-parallel and demux stages.
package paralelo_serial_pkg;

    localparam int unsigned WIDTH_DEF      = 8;
    localparam logic [7:0]  IDLE_SYM       = 8'hBC;
    localparam int unsigned SYNC_WORDS_DEF = 4;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/paralelo_serial.sv
// Parallel-to-serial stage: sends a COM preamble after reset, then shifts each
// sampled word out MSB-first, inserting IDLE whenever valid_in is low.
module paralelo_serial
    import paralelo_serial_pkg::*;
#(
    parameter int unsigned      WIDTH      = WIDTH_DEF,
    parameter logic [WIDTH-1:0] IDLE       = WIDTH'(IDLE_SYM),
    parameter int unsigned      SYNC_WORDS = SYNC_WORDS_DEF
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             data_out,
    output logic             sample,
    output logic             sync_done
);

    localparam int unsigned       CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned       SCNT_W    = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SYNC_WORDS - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [SCNT_W-1:0] r_scnt;
    logic [WIDTH-1:0]  r_word;
    logic              r_data_out;
    logic              r_sample;
    logic              r_sync_done;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [SCNT_W-1:0] w_scnt_nxt;
    logic [WIDTH-1:0]  w_word_nxt;
    logic              w_data_out_nxt;
    logic              w_sample_nxt;
    logic              w_sync_done_nxt;
    logic              w_boundary;
    logic [WIDTH-1:0]  w_load_word;

    assign w_boundary  = (r_cnt == CNT_LAST);
    assign w_load_word = valid_in ? data_in : IDLE;

    // State register plus serial datapath registers.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state     <= SYNC;
            r_cnt       <= '0;
            r_scnt      <= '0;
            r_word      <= IDLE;
            r_data_out  <= 1'b0;
            r_sample    <= 1'b0;
            r_sync_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_scnt      <= w_scnt_nxt;
            r_word      <= w_word_nxt;
            r_data_out  <= w_data_out_nxt;
            r_sample    <= w_sample_nxt;
            r_sync_done <= w_sync_done_nxt;
        end
    end

    // Next-state: the word register only reloads on the last bit of a word.
    always_comb begin
        w_state_nxt     = r_state;
        w_scnt_nxt      = r_scnt;
        w_word_nxt      = r_word;
        w_sync_done_nxt = r_sync_done;
        w_cnt_nxt       = w_boundary ? '0 : r_cnt + CNT_W'(1);
        w_data_out_nxt  = r_word[CNT_LAST - r_cnt];

        if (w_boundary) begin
            case (r_state)
                SYNC: begin
                    if (r_scnt == SCNT_LAST) begin
                        w_state_nxt     = ACTIVE;
                        w_sync_done_nxt = 1'b1;
                        w_word_nxt      = w_load_word;
                    end else begin
                        w_word_nxt = IDLE;
                        w_scnt_nxt = r_scnt + SCNT_W'(1);
                    end
                end
                ACTIVE: begin
                    w_word_nxt = w_load_word;
                end
                default: begin
                    w_state_nxt = SYNC;
                end
            endcase
        end

        // Registered look-ahead of the sample strobe for the coming cycle.
        w_sample_nxt = (w_cnt_nxt == CNT_LAST) &&
                       ((w_state_nxt == ACTIVE) || (w_scnt_nxt == SCNT_LAST));
    end

    assign data_out  = r_data_out;
    assign sample    = r_sample;
    assign sync_done = r_sync_done;

endmodule

// File: tb/tb_paralelo_serial.sv
// Directed bench for paralelo_serial: preamble, serialisation, IDLE insertion,
// back-to-back words, mid-word reset and a single-word preamble variant.
module tb_paralelo_serial;

    localparam logic [7:0] IDLE_B = 8'hBC;

    logic       clk_32f  = 1'b0;
    logic       reset    = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] data_in  = 8'h00;
    logic       data_out, sample, sync_done;
    logic       data_out1, sample1, sync_done1;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    always #5 clk_32f = ~clk_32f;

    paralelo_serial #(.WIDTH(8), .IDLE(8'hBC), .SYNC_WORDS(4)) dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .valid_in (valid_in),
        .data_in  (data_in),
        .data_out (data_out),
        .sample   (sample),
        .sync_done(sync_done)
    );

    paralelo_serial #(.WIDTH(8), .IDLE(8'hBC), .SYNC_WORDS(1)) dut1 (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .valid_in (valid_in),
        .data_in  (data_in),
        .data_out (data_out1),
        .sample   (sample1),
        .sync_done(sync_done1)
    );

    task automatic step;
        @(posedge clk_32f);
        #1;
        edge_n++;
    endtask

    // Two reset edges, then release; edge_n counts edges from release.
    task automatic test_reset;
        reset = 1'b1; valid_in = 1'b0; data_in = 8'h00;
        step; step;
        checks++; if (data_out !== 1'b0) begin errors++; $display("FAIL reset_data_out got %b want 0", data_out); end
        checks++; if (sync_done !== 1'b0) begin errors++; $display("FAIL reset_sync_done got %b want 0", sync_done); end
        checks++; if (sample !== 1'b0) begin errors++; $display("FAIL reset_sample got %b want 0", sample); end
        reset  = 1'b0;
        edge_n = 0;
    endtask

    // Edges 1..31 of a 4-word preamble on dut.
    task automatic run_preamble(input string tag);
        for (int e = 1; e <= 31; e++) begin
            step;
            checks++;
            if (data_out !== IDLE_B[7 - ((e - 1) % 8)]) begin
                errors++; $display("FAIL %s_bit e%0d got %b want %b", tag, e, data_out, IDLE_B[7 - ((e - 1) % 8)]);
            end
            checks++;
            if (sample !== (e == 31)) begin
                errors++; $display("FAIL %s_sample e%0d got %b want %b", tag, e, sample, (e == 31));
            end
            checks++;
            if (sync_done !== 1'b0) begin
                errors++; $display("FAIL %s_sync_done e%0d got %b want 0", tag, e, sync_done);
            end
        end
    endtask

    task automatic test_sync_preamble;
        valid_in = 1'b0; data_in = 8'h00;
        run_preamble("sync");
    endtask

    // A5 sampled at edge 32, shifted out on edges 33..40.
    task automatic test_first_word;
        logic [7:0] w = 8'hA5;
        valid_in = 1'b1; data_in = 8'hA5;
        step;
        checks++; if (sync_done !== 1'b1) begin errors++; $display("FAIL first_sync_done got %b want 1", sync_done); end
        checks++; if (data_out !== 1'b0) begin errors++; $display("FAIL first_idle_lsb got %b want 0", data_out); end
        checks++; if (sample !== 1'b0) begin errors++; $display("FAIL first_sample_e32 got %b want 0", sample); end
        for (int i = 0; i < 7; i++) begin
            step;
            checks++;
            if (data_out !== w[7 - i]) begin errors++; $display("FAIL first_bit e%0d got %b want %b", edge_n, data_out, w[7 - i]); end
            checks++;
            if (sample !== (edge_n % 8 == 7)) begin errors++; $display("FAIL first_sample e%0d got %b want %b", edge_n, sample, (edge_n % 8 == 7)); end
        end
    endtask

    // valid_in low with data_in=FF at edge 40 must produce IDLE.
    task automatic test_idle_insert;
        valid_in = 1'b0; data_in = 8'hFF;
        step;
        checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL idle_prev_lsb got %b want 1", data_out); end
        for (int i = 0; i < 7; i++) begin
            step;
            checks++;
            if (data_out !== IDLE_B[7 - i]) begin errors++; $display("FAIL idle_bit e%0d got %b want %b", edge_n, data_out, IDLE_B[7 - i]); end
            checks++;
            if (sample !== (edge_n % 8 == 7)) begin errors++; $display("FAIL idle_sample e%0d got %b want %b", edge_n, sample, (edge_n % 8 == 7)); end
        end
    endtask

    // 00 then FF back to back; A5 is loaded at edge 64 for the reset test.
    task automatic test_back_to_back;
        logic [7:0] w;
        valid_in = 1'b1; data_in = 8'h00;
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 8'h00 : 8'hFF;
            step;
            checks++;
            if (data_out !== ((k == 0) ? IDLE_B[0] : 1'b0)) begin
                errors++; $display("FAIL b2b_lsb e%0d got %b want %b", edge_n, data_out, ((k == 0) ? IDLE_B[0] : 1'b0));
            end
            for (int i = 0; i < 7; i++) begin
                step;
                checks++;
                if (data_out !== w[7 - i]) begin errors++; $display("FAIL b2b_bit e%0d got %b want %b", edge_n, data_out, w[7 - i]); end
                checks++;
                if (sample !== (edge_n % 8 == 7)) begin errors++; $display("FAIL b2b_sample e%0d got %b want %b", edge_n, sample, (edge_n % 8 == 7)); end
            end
            data_in = 8'hFF;
        end
        data_in = 8'hA5;
        step;
        checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL b2b_last_lsb got %b want 1", data_out); end
    endtask

    // Reset after 3 bits of A5: preamble restarts in full.
    task automatic test_reset_mid_word;
        logic [7:0] w = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            step;
            checks++;
            if (data_out !== w[7 - i]) begin errors++; $display("FAIL mid_bit i%0d got %b want %b", i, data_out, w[7 - i]); end
        end
        reset = 1'b1;
        step;
        checks++; if (data_out !== 1'b0) begin errors++; $display("FAIL mid_reset_data_out got %b want 0", data_out); end
        checks++; if (sync_done !== 1'b0) begin errors++; $display("FAIL mid_reset_sync_done got %b want 0", sync_done); end
        reset = 1'b0; edge_n = 0;
        valid_in = 1'b1; data_in = 8'hA5;
        run_preamble("resync");
        step;
        checks++; if (sync_done !== 1'b1) begin errors++; $display("FAIL resync_done got %b want 1", sync_done); end
        step;
        checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL resync_msb got %b want 1", data_out); end
    endtask

    // SYNC_WORDS=1: only the reset-value IDLE word precedes the first sample.
    task automatic test_sync_words1;
        logic [7:0] w = 8'h3C;
        reset = 1'b1; step; step;
        reset = 1'b0; edge_n = 0;
        valid_in = 1'b1; data_in = 8'h3C;
        for (int e = 1; e <= 16; e++) begin
            step;
            checks++;
            if (e <= 8) begin
                if (data_out1 !== IDLE_B[8 - e]) begin errors++; $display("FAIL sw1_idle_bit e%0d got %b want %b", e, data_out1, IDLE_B[8 - e]); end
            end else begin
                if (data_out1 !== w[16 - e]) begin errors++; $display("FAIL sw1_data_bit e%0d got %b want %b", e, data_out1, w[16 - e]); end
            end
            checks++;
            if (sample1 !== (e == 7 || e == 15)) begin errors++; $display("FAIL sw1_sample e%0d got %b want %b", e, sample1, (e == 7 || e == 15)); end
            checks++;
            if (sync_done1 !== (e >= 8)) begin errors++; $display("FAIL sw1_sync_done e%0d got %b want %b", e, sync_done1, (e >= 8)); end
        end
    endtask

    initial begin
        test_reset;
        test_sync_preamble;
        test_first_word;
        test_idle_insert;
        test_back_to_back;
        test_reset_mid_word;
        test_sync_words1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/paralelo_serial.md
Name: paralelo_serial

Overview:
Downstream stage of the 4:1 byte mux. Takes the muxed 8-bit word and its valid flag and serialises the word MSB-first onto one line at 8x the byte rate. After reset it first sends a fixed number of IDLE (COM) symbols so the receiver can lock. When valid is low it inserts an IDLE symbol, so the line never goes silent.
Runs entirely in the clk_32f domain; the upstream byte stream is held stable across each 8-cycle word window.

Parameters:
WIDTH, 8, word width in bits; the bit counter wraps at WIDTH.
IDLE, 8'hBC, symbol sent during sync and whenever valid_in is low.
SYNC_WORDS, 4, number of IDLE words sent after reset before data is accepted (must be >= 1).

Ports:
clk_32f  input  1  single clock, rising edge; serial bit rate.
reset  input  1  synchronous, active-high reset.
valid_in  input  1  data_in holds a real word.
data_in  input  WIDTH  parallel word from the mux.
data_out  output  1  serial line, MSB first, registered.
sample  output  1  high during the cycle whose closing edge samples valid_in/data_in.
sync_done  output  1  high once the sync preamble is complete.

Behaviour:
- Internal state: bit counter cnt[log2 WIDTH], word register word[WIDTH], state {SYNC, ACTIVE}, sync counter scnt.
- Reset (reset=1 at a rising edge): cnt=0, word=IDLE, state=SYNC, scnt=0, data_out=0, sync_done=0.
- Reset has priority over every other event. Reset mid-word aborts the word, and the next edge with reset=0 restarts the full preamble.
- Every non-reset edge:
  - data_out <= word[WIDTH-1-cnt].
  - cnt <= (cnt == WIDTH-1) ? 0 : cnt+1.
- Word boundary = an edge with cnt == WIDTH-1; word is reloaded only at boundaries:
  - SYNC and scnt < SYNC_WORDS-1: word <= IDLE, scnt <= scnt+1.
  - SYNC and scnt == SYNC_WORDS-1: state <= ACTIVE, sync_done <= 1, and the word is loaded by the ACTIVE rule.
  - ACTIVE: word <= valid_in ? data_in : IDLE.
- Result: exactly SYNC_WORDS IDLE words are emitted, the reset-value word included, before the first sampled word.
- sample = (cnt == WIDTH-1) && (state == ACTIVE || scnt == SYNC_WORDS-1).
  - Decoded from registers only; no combinational path from inputs to outputs.
  - Asserts once every WIDTH cycles in ACTIVE.
- Latency: a word sampled at boundary edge E has its MSB on data_out after E+1 and its LSB after E+WIDTH. Consecutive words follow with no gap bits.
- When valid_in=0 in ACTIVE, data_in is ignored entirely.
- sync_done stays 1 until the next reset.
- The ACTIVE state never returns to SYNC except through reset.

Decomposition:
- Shared package: IDLE symbol constant (8'hBC), the state encoding {SYNC, ACTIVE}, and WIDTH default. The matching serial-to-parallel and demux stages reuse these.
- No sub-module needed. The bit counter and shift path stay inline; a separate counter module is not warranted at this size.

Test Plan:
1. reset high 2 edges, release (edge 1 = first edge with reset=0), valid_in=0:
   - data_out carries 10111100 four times.
   - sample is high only in the cycle before edge 32.
   - sync_done rises after edge 32.
2. After sync, valid_in=1, data_in=8'hA5 held through edge 32:
   - data_out after edges 33..40 = 1,0,1,0,0,1,0,1.
3. ACTIVE, valid_in=0, data_in=8'hFF at a boundary -> next 8 bits = 10111100 (IDLE), not 11111111.
4. Back-to-back valid words 8'h00 then 8'hFF:
   - 8 zeros then 8 ones, no gap bits.
   - sample pulses exactly every 8 cycles.
5. reset asserted after 3 bits of a data word:
   - Next edge: data_out=0, sync_done=0.
   - After release, four full IDLE words again before the next sample.
6. SYNC_WORDS=1:
   - First boundary (edge 8 after release) already samples data_in.
   - sync_done rises after edge 8.
   - Only one IDLE word is emitted.
